// File: rtl/ovl_width_checker.sv
// Pulse-width assertion checker: each high window of test_expr must last
// between min_cks and max_cks sampled cycles; violations pulse on fire[0].
module ovl_width_checker #(
    parameter int unsigned min_cks = 1,
    parameter int unsigned max_cks = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       test_expr,
    output logic [2:0] fire
);

    logic             prev;
    logic [CNT_W-1:0] count;
    logic             max_flag;

    logic expr;
    logic rise;
    logic hold;
    logic fall;
    logic min_v;
    logic max_v;
    logic sat;

    // Unknown or floating samples count as low.
    assign expr = (test_expr === 1'b1);

    assign rise = expr & ~prev;
    assign hold = expr & prev;
    assign fall = ~expr & prev;
    assign sat  = (count == {CNT_W{1'b1}});

    assign min_v = (min_cks != 0) && fall
                && (32'(count) < min_cks);
    assign max_v = (max_cks != 0) && hold && !max_flag
                && (32'(count) >= max_cks);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev     <= 1'b0;
            count    <= '0;
            max_flag <= 1'b0;
            fire     <= 3'b000;
        end else begin
            prev <= expr;
            if (rise) begin
                count    <= {{(CNT_W-1){1'b0}}, 1'b1};
                max_flag <= 1'b0;
            end else if (hold) begin
                if (!sat)
                    count <= count + 1'b1;
                if (max_v)
                    max_flag <= 1'b1;
            end else begin
                count    <= '0;
                max_flag <= 1'b0;
            end
            fire <= {enable & rise, 1'b0, enable & (min_v | max_v)};
        end
    end

endmodule

// File: tb/tb_ovl_width_checker.sv
// Bench for ovl_width_checker: directed scenarios plus random pulses,
// checked against a sample-history model of the width rules.
module tb_ovl_width_checker;

    localparam int MIN = 2;
    localparam int MAX = 3;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       test_expr;
    logic [2:0] fire;

    int checks;
    int failures;

    bit         hist[$];
    logic [2:0] exp_fire;

    ovl_width_checker #(
        .min_cks(MIN),
        .max_cks(MAX),
        .CNT_W  (16)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .test_expr(test_expr),
        .fire     (fire)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Length of the run of ones ending at index last.
    function automatic int streak(input int last);
        int len;
        len = 0;
        for (int k = last; k >= 0; k--) begin
            if (!hist[k])
                break;
            len++;
        end
        return len;
    endfunction

    function automatic logic [2:0] model(input logic en);
        int n;
        bit cur;
        bit prv;
        bit rise;
        bit viol;
        n = hist.size();
        if (n == 0)
            return 3'b000;
        cur  = hist[n-1];
        prv  = (n > 1) ? hist[n-2] : 1'b0;
        rise = cur && !prv;
        viol = 1'b0;
        if (!cur && prv && streak(n-2) < MIN)
            viol = 1'b1;
        if (cur && streak(n-1) == MAX + 1)
            viol = 1'b1;
        if (en !== 1'b1)
            return 3'b000;
        return {rise, 1'b0, viol};
    endfunction

    // Drive one sample, advance past the edge, update the model.
    task automatic step(input logic e, input logic en);
        @(negedge clock);
        test_expr = e;
        enable    = en;
        @(posedge clock);
        if (reset === 1'b1)
            hist.push_back(e === 1'b1);
        else
            hist.delete();
        exp_fire = model(en);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        hist.delete();
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        checks++;
        if (fire !== exp_fire) begin
            failures++;
            $display("FAIL pre_reset_rise got=%b want=%b", fire, exp_fire);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (fire !== 3'b000) begin
            failures++;
            $display("FAIL async_reset got=%b want=000", fire);
        end
        for (int i = 0; i < 4; i++) begin
            step(i[0], 1'b1);
            checks++;
            if (fire !== 3'b000) begin
                failures++;
                $display("FAIL reset_hold[%0d] got=%b want=000", i, fire);
            end
        end
    endtask

    task automatic test_idle_legal2();
        logic v[5];
        v = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(v[i], 1'b1);
            checks++;
            if (fire !== exp_fire || (i == 2 && fire !== 3'b100)) begin
                failures++;
                $display("FAIL legal2[%0d] got=%b want=%b", i, fire, exp_fire);
            end
        end
    endtask

    task automatic test_legal3();
        for (int i = 0; i < 8; i++) begin
            step(i < 3, 1'b1);
            checks++;
            if (fire !== exp_fire || fire[0] !== 1'b0) begin
                failures++;
                $display("FAIL legal3[%0d] got=%b want=%b", i, fire, exp_fire);
            end
        end
    endtask

    task automatic test_short();
        for (int i = 0; i < 4; i++) begin
            step(i == 0, 1'b1);
            checks++;
            if (fire !== exp_fire || fire[0] !== (i == 1)) begin
                failures++;
                $display("FAIL short[%0d] got=%b want=%b", i, fire, exp_fire);
            end
        end
    endtask

    task automatic test_long();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 9; i++) begin
            step(i < 6, 1'b1);
            pulses += fire[0];
            checks++;
            if (fire !== exp_fire || fire[0] !== (i == 3)) begin
                failures++;
                $display("FAIL long[%0d] got=%b want=%b", i, fire, exp_fire);
            end
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL long_pulses got=%0d want=1", pulses);
        end
    endtask

    task automatic test_enable();
        for (int i = 0; i < 3; i++) begin
            step(i == 0, 1'b0);
            checks++;
            if (fire !== 3'b000) begin
                failures++;
                $display("FAIL gated[%0d] got=%b want=000", i, fire);
            end
        end
        for (int i = 0; i < 7; i++) begin
            step(i < 5, i >= 2);
            checks++;
            if (fire !== exp_fire || fire[0] !== (i == 3)) begin
                failures++;
                $display("FAIL reenable[%0d] got=%b want=%b", i, fire, exp_fire);
            end
        end
    endtask

    task automatic test_x_input();
        logic v[5];
        v = '{1'b0, 1'bx, 1'b1, 1'bz, 1'b0};
        for (int i = 0; i < 5; i++) begin
            step(v[i], 1'b1);
            checks++;
            if (fire !== exp_fire || fire[1] !== 1'b0) begin
                failures++;
                $display("FAIL xinput[%0d] got=%b want=%b", i, fire, exp_fire);
            end
        end
    endtask

    task automatic test_reset_high();
        reset = 1'b0;
        step(1'b1, 1'b1);
        reset = 1'b1;
        step(1'b1, 1'b1);
        checks++;
        if (fire !== exp_fire || fire !== 3'b100) begin
            failures++;
            $display("FAIL reset_high_rise got=%b want=100", fire);
        end
        for (int i = 0; i < 4; i++) begin
            step(i < 2, 1'b1);
            checks++;
            if (fire !== exp_fire) begin
                failures++;
                $display("FAIL reset_high[%0d] got=%b want=%b", i, fire, exp_fire);
            end
        end
    endtask

    task automatic test_random();
        logic lvl;
        int   len;
        lvl = 1'b0;
        for (int r = 0; r < 120; r++) begin
            lvl = ~lvl;
            len = $urandom_range(1, 6);
            for (int j = 0; j < len; j++) begin
                step(lvl, ($urandom_range(0, 4) != 0));
                checks++;
                if (fire !== exp_fire) begin
                    failures++;
                    $display("FAIL random[%0d.%0d] got=%b want=%b",
                             r, j, fire, exp_fire);
                end
            end
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        enable    = 1'b0;
        test_expr = 1'b0;
        exp_fire  = 3'b000;
        test_reset();
        test_idle_legal2();
        test_legal3();
        test_short();
        test_long();
        test_enable();
        test_x_input();
        test_reset_high();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
